// File: rtl/imem_loader.sv
// Boot-time program loader: takes a header byte (word count - 1) followed by a
// little-endian byte stream, writes the words into instruction memory, then releases the core.
module imem_loader #(
  parameter int IMW = 5,
  parameter int IW  = 32
) (
  input  logic           clk,
  input  logic           start,
  input  logic           in_valid,
  input  logic [7:0]     in_byte,
  output logic           in_ready,
  output logic           im_we,
  output logic [IMW-1:0] im_addr,
  output logic [IW-1:0]  im_wdata,
  output logic           core_start,
  output logic           load_err
);

  localparam int BPW   = IW / 8;
  localparam int BCW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int DEPTH = 1 << IMW;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    DATA = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [BCW-1:0] byte_cnt;
  logic [IMW-1:0] word_idx;
  logic [IMW-1:0] last;
  logic [IW-1:0]  word_buf;
  logic [IW-1:0]  assembled;
  logic           accept;
  logic           hdr_bad;
  logic           word_end;
  logic           load_end;
  logic           in_ready_d;
  logic           im_we_d;
  logic           core_start_d;
  logic           load_err_d;

  assign accept   = in_valid && in_ready;
  // 9-bit compare so IMW=8 (depth 256) never flags a header as too large
  assign hdr_bad  = ({1'b0, in_byte} >= 9'(DEPTH));
  assign word_end = (byte_cnt == BCW'(BPW - 1));
  assign load_end = word_end && (word_idx == last);

  // Current word with the incoming byte merged into its little-endian lane
  always_comb begin
    assembled = word_buf;
    for (int k = 0; k < BPW; k++) begin
      if (byte_cnt == BCW'(k)) begin
        assembled[8*k +: 8] = in_byte;
      end else begin
        assembled[8*k +: 8] = word_buf[8*k +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state <= HDR;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      HDR: begin
        if (accept) begin
          next_state = hdr_bad ? ERR : DATA;
        end else begin
          next_state = HDR;
        end
      end
      DATA: begin
        if (accept && load_end) begin
          next_state = DONE;
        end else begin
          next_state = DATA;
        end
      end
      DONE:    next_state = DONE;
      ERR:     next_state = ERR;
      default: next_state = ERR;
    endcase
  end

  // Next values of the registered control outputs
  always_comb begin
    in_ready_d   = (next_state == HDR) || (next_state == DATA);
    im_we_d      = accept && (state == DATA) && word_end;
    core_start_d = (state == DONE);
    load_err_d   = (next_state == ERR);
  end

  // Registered control outputs
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      in_ready   <= 1'b0;
      im_we      <= 1'b0;
      core_start <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      in_ready   <= in_ready_d;
      im_we      <= im_we_d;
      core_start <= core_start_d;
      load_err   <= load_err_d;
    end
  end

  // Header latch, byte assembly, word counter and write address/data
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      last     <= {IMW{1'b0}};
      byte_cnt <= {BCW{1'b0}};
      word_idx <= {IMW{1'b0}};
      word_buf <= {IW{1'b0}};
      im_addr  <= {IMW{1'b0}};
      im_wdata <= {IW{1'b0}};
    end else begin
      if (accept && (state == HDR) && !hdr_bad) begin
        last <= in_byte[IMW-1:0];
      end
      if (accept && (state == DATA)) begin
        word_buf <= assembled;
        if (word_end) begin
          byte_cnt <= {BCW{1'b0}};
          word_idx <= word_idx + IMW'(1'b1);
          im_addr  <= word_idx;
          im_wdata <= assembled;
        end else begin
          byte_cnt <= byte_cnt + BCW'(1'b1);
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of single-word/header cases plus
// hand-written multi-word, random-gap, mid-load reset and post-DONE sequences.
module tb_imem_loader;
  localparam int IMW = 5;
  localparam int IW  = 32;

  logic           clk = 1'b0;
  logic           start = 1'b0;
  logic           in_valid = 1'b0;
  logic [7:0]     in_byte = 8'h00;
  logic           in_ready;
  logic           im_we;
  logic [IMW-1:0] im_addr;
  logic [IW-1:0]  im_wdata;
  logic           core_start;
  logic           load_err;

  int checks = 0;
  int failures = 0;

  logic [IMW-1:0] wa[$];
  logic [IW-1:0]  wd[$];
  int   consec = 0;
  int   cs_rises = 0;
  logic prev_we = 1'b0;
  logic prev_cs = 1'b0;

  imem_loader #(.IMW(IMW), .IW(IW)) dut (
    .clk(clk), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .core_start(core_start), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Write and core_start monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (im_we) begin
      wa.push_back(im_addr);
      wd.push_back(im_wdata);
    end
    if (im_we && prev_we) consec <= consec + 1;
    if (core_start && !prev_cs) cs_rises <= cs_rises + 1;
    prev_we <= im_we;
    prev_cs <= core_start;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_ctrl", {28'd0, in_ready, im_we, core_start, load_err}, 32'd0);
    check("rst_addr", 32'(im_addr), 32'd0);
    check("rst_wdata", im_wdata, 32'd0);
    repeat (2) @(negedge clk);
    start = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_byte = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout: in_ready still 0 after %0d cycles, byte 0x%0h", n, b);
    end else begin
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_byte(w[8*k +: 8]);
    end
  endtask

  typedef struct {
    logic [7:0]  hdr;
    logic [31:0] word;
    logic        err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int base;
    int rbase;
    int cbase;
    logic [31:0] exp_words[32];
    logic [7:0]  b;

    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int rbase;
    int cbase;
    logic [31:0] exp_words[32];
    logic [7:0]  b;

    vecs[0] = '{hdr: 8'h00, word: 32'h0000_0013, err: 1'b0};
    vecs[1] = '{hdr: 8'h00, word: 32'hDEAD_BEEF, err: 1'b0};
    vecs[2] = '{hdr: 8'h20, word: 32'h0000_0000, err: 1'b1};
    vecs[3] = '{hdr: 8'hFF, word: 32'h0000_0000, err: 1'b1};
    vecs[4] = '{hdr: 8'h00, word: 32'h8000_0001, err: 1'b0};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      base = wa.size();
      send_byte(vecs[i].hdr);
      if (!vecs[i].err) begin
        send_word(vecs[i].word, 0);
        @(negedge clk);
        check("v_we", {31'd0, im_we}, 32'd1);
        check("v_addr", 32'(im_addr), 32'd0);
        check("v_wdata", im_wdata, vecs[i].word);
        check("v_cs_early", {31'd0, core_start}, 32'd0);
        check("v_rdy_done", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("v_cs", {31'd0, core_start}, 32'd1);
        check("v_we_off", {31'd0, im_we}, 32'd0);
        check("v_err", {31'd0, load_err}, 32'd0);
      end else begin
        @(negedge clk);
        check("e_err", {31'd0, load_err}, 32'd1);
        check("e_rdy", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_byte = 8'h55;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        check("e_writes", 32'(wa.size() - base), 32'd0);
        check("e_cs", {31'd0, core_start}, 32'd0);
        check("e_err_hold", {31'd0, load_err}, 32'd1);
      end
    end

    // three-word load, then bytes offered after DONE
    do_reset();
    base = wa.size();
    rbase = cs_rises;
    cbase = consec;
    send_byte(8'h02);
    send_word(32'hAABB_CCDD, 0);
    send_word(32'h1122_3344, 0);
    send_word(32'h0000_0000, 0);
    repeat (3) @(negedge clk);
    check("m_writes", 32'(wa.size() - base), 32'd3);
    check("m_addr0", 32'(wa[base]), 32'd0);
    check("m_data0", wd[base], 32'hAABB_CCDD);
    check("m_addr1", 32'(wa[base+1]), 32'd1);
    check("m_data1", wd[base+1], 32'h1122_3344);
    check("m_addr2", 32'(wa[base+2]), 32'd2);
    check("m_data2", wd[base+2], 32'h0000_0000);
    check("m_rdy", {31'd0, in_ready}, 32'd0);
    check("m_cs", {31'd0, core_start}, 32'd1);
    base = wa.size();
    in_valid = 1'b1;
    in_byte = 8'h99;
    repeat (5) @(negedge clk);
    check("x_rdy", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    check("x_writes", 32'(wa.size() - base), 32'd0);
    check("x_cs", {31'd0, core_start}, 32'd1);
    check("x_rises", 32'(cs_rises - rbase), 32'd1);

    // full memory with random valid gaps
    do_reset();
    base = wa.size();
    rbase = cs_rises;
    cbase = consec;
    for (int w = 0; w < 32; w++) begin
      b = 8'(w);
      exp_words[w] = {b, b ^ 8'hA5, b + 8'h3C, ~b};
    end
    send_byte(8'h1F);
    for (int w = 0; w < 32; w++) send_word(exp_words[w], 2);
    repeat (3) @(negedge clk);
    check("f_writes", 32'(wa.size() - base), 32'd32);
    if (wa.size() - base == 32) begin
      for (int w = 0; w < 32; w++) begin
        check("f_addr", 32'(wa[base+w]), 32'(w));
        check("f_data", wd[base+w], exp_words[w]);
      end
    end
    check("f_rises", 32'(cs_rises - rbase), 32'd1);
    check("f_consec", 32'(consec - cbase), 32'd0);
    check("f_err", {31'd0, load_err}, 32'd0);

    // reset in the middle of the second word, then a fresh one-word load
    do_reset();
    send_byte(8'h01);
    send_word(32'h0403_0201, 0);
    send_byte(8'h05);
    send_byte(8'h06);
    do_reset();
    base = wa.size();
    send_byte(8'h00);
    send_word(32'h4455_6677, 0);
    repeat (3) @(negedge clk);
    check("r_writes", 32'(wa.size() - base), 32'd1);
    if (wa.size() > base) begin
      check("r_addr", 32'(wa[base]), 32'd0);
      check("r_data", wd[base], 32'h4455_6677);
    end
    check("r_cs", {31'd0, core_start}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
